uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the board's single USB-serial transmitter between several byte-stream requesters. Each requester delivers a packet of bytes over a valid/ready handshake. The arbiter grants one requester at a time, optionally prefixes the packet with a one-byte source header, and paces bytes into the UART transmitter using its busy flag. It sits between the application logic and the uart_tx instance that drives `usb_tx` in the top level.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `HEADER_EN`, 1: when 1, each packet is preceded by a header byte.
- `HEADER_BASE`, 8'hA0: header byte is `HEADER_BASE | index`; the low 4 bits of `HEADER_BASE` must be 0.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset (from the reset conditioner).
- `req_data`  in  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_last`  in  NUM_REQ  the byte is the final byte of its packet.
- `req_ready`  out  NUM_REQ  byte i accepted this cycle (transfer = valid & ready).
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_new_data`  out  1  single-cycle strobe: UART samples `tx_data`.
- `tx_busy`  in  1  UART is shifting a byte.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `active`  out  1  a packet is in progress (state ≠ IDLE).

## Operation
- **States:** IDLE, HEADER, DATA. State, grant and pointer are registered.
- **IDLE:**
  - If any `req_valid` is high, pick the first valid index searching `ptr+1, ptr+2, …` modulo NUM_REQ.
  - Load `grant` with that index one-hot and set `ptr` to that index.
  - Go to HEADER if HEADER_EN=1, otherwise DATA.
- **`send_ok`** = `!tx_busy && !holdoff`.
  - `holdoff` is a register set for exactly one cycle after every `tx_new_data` pulse. It covers the cycle before the UART raises busy.
- **HEADER:**
  - When `send_ok`: `tx_data = HEADER_BASE | idx`, `tx_new_data = 1`, go to DATA.
  - No `req_ready` is asserted in HEADER.
- **DATA:**
  - `req_ready[idx] = send_ok`.
  - `tx_new_data = send_ok && req_valid[idx]`; `tx_data = req_data[idx]`.
  - On a transfer with `req_last[idx] = 1`: go to IDLE and clear `grant` on the next cycle.
- **Combinational outputs:** `req_ready`, `tx_new_data` and `tx_data` are combinational from registered state plus `tx_busy` and the `req_*` inputs.
  - `tx_data` is 8'h00 whenever `tx_new_data` = 0.
  - `req_ready` bits of non-granted requesters are always 0.
- **Valid deasserts mid-packet:** the grant is held indefinitely; there is no timeout. The owner must finish its packet with a `last` byte.
- **Fairness:**
  - A requester that just finished has lowest priority at the next arbitration.
  - A requester that is continuously valid waits at most NUM_REQ−1 packets.
- **Reset:**
  - `rst` in any state → IDLE next edge.
  - `grant` = 0, `active` = 0, `holdoff` = 0, `ptr` = NUM_REQ−1, so requester 0 wins first.
  - A byte already handed to the UART finishes on the line; it is not this block's concern.
  - Outputs during reset: `req_ready` = 0, `tx_new_data` = 0, `tx_data` = 0.
- **Single-byte packet:** `last` on the first data byte is legal; the packet is header plus one byte, or one byte with HEADER_EN=0.

## Timing
- **Arbitration:** valid seen in IDLE at edge N → `grant`/`active` high after edge N.
  - The header (or first byte) strobe can occur in cycle N+1 if `tx_busy` = 0.
- **Strobe spacing:** consecutive `tx_new_data` pulses are at least 2 cycles apart because of `holdoff`.
  - At runtime they are further throttled by `tx_busy`.
- **End of packet:** last-byte transfer in cycle M → IDLE from cycle M+1; a new grant is visible from cycle M+2.
  - IDLE therefore lasts at least 1 cycle between packets.
- **Throughput bound:** one byte per UART frame time; the arbiter adds no wait beyond `holdoff` and `tx_busy`.

## Test plan
- **Reset mid-packet:** HEADER_EN=1, requester 1 mid-packet, `tx_busy` = 0; assert `rst` for one cycle → next cycle `grant` = 0, `active` = 0, no strobe. With requesters 0 and 2 valid, requester 0 is granted first.
- **Single packet with header:** HEADER_EN=1, requester 2 sends 8'h41, 8'h42 (last) with `tx_busy` modelled at 10 cycles per byte → UART sees 8'hA2, 8'h41, 8'h42 in order. `req_ready[2]` pulses exactly twice, and IDLE is reached one cycle after the 8'h42 transfer.
- **Round-robin rotation:** requesters 0, 1 and 3 each continuously valid with 2-byte packets → grant order is 0, 1, 3, 0, 1, 3. No packet interleaving; each packet stays contiguous on `tx_data`.
- **Throttling:** hold `tx_busy` = 1 for 50 cycles during DATA → no `tx_new_data` and no `req_ready` for those 50 cycles. The byte is sent in the first cycle where `tx_busy` = 0 and `holdoff` = 0.
- **Owner stall:** HEADER_EN=0; the owner drops valid for 20 cycles mid-packet while another requester is valid → grant unchanged, no strobes. The stalled packet resumes and completes before the other requester is granted.
- **Strobe spacing:** with `tx_busy` tied 0 → `tx_new_data` pulses are never adjacent (minimum spacing 2 cycles) for a 4-byte packet.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter between NUM_REQ byte-stream requesters.
// Optional per-packet source header; bytes are paced by tx_busy plus a one-cycle holdoff after each strobe.
module uart_tx_arbiter #(
   parameter int         NUM_REQ     = 4,
   parameter bit         HEADER_EN   = 1'b1,
   parameter logic [7:0] HEADER_BASE = 8'hA0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_new_data,
   input  logic                 tx_busy,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 active
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, DATA = 2'd2} state_t;

   state_t             state, state_nxt;
   logic [IW-1:0]      ptr, pick;
   logic [NUM_REQ-1:0] pick_oh;
   logic               pick_vld;
   logic               holdoff;
   logic               send_ok;
   logic               owner_valid, owner_last;
   logic [7:0]         owner_data;

   // ptr always holds the current owner while a packet is in progress
   assign send_ok     = !tx_busy && !holdoff;
   assign owner_valid = req_valid[ptr];
   assign owner_last  = req_last[ptr];
   assign owner_data  = req_data[{ptr, 3'b000} +: 8];
   assign active      = (state != IDLE);
   assign pick_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;

   always_comb begin
      int c;
      pick_vld = 1'b0;
      pick     = '0;
      c        = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (!pick_vld && req_valid[c[IW-1:0]]) begin
            pick_vld = 1'b1;
            pick     = c[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant   <= '0;
         ptr     <= IW'(NUM_REQ - 1);
         holdoff <= 1'b0;
      end else begin
         state   <= state_nxt;
         holdoff <= tx_new_data;
         if (state == IDLE && pick_vld) begin
            grant <= pick_oh;
            ptr   <= pick;
         end else if (state == DATA && state_nxt == IDLE) begin
            grant <= '0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld) state_nxt = HEADER_EN ? HEADER : DATA;
         HEADER:  if (send_ok) state_nxt = DATA;
         DATA:    if (send_ok && owner_valid && owner_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = '0;
      tx_new_data = 1'b0;
      tx_data     = 8'h00;
      if (!rst) begin
         case (state)
            HEADER: begin
               if (send_ok) begin
                  tx_new_data = 1'b1;
                  tx_data     = HEADER_BASE | {{(8-IW){1'b0}}, ptr};
               end
            end
            DATA: begin
               req_ready[ptr] = send_ok;
               if (send_ok && owner_valid) begin
                  tx_new_data = 1'b1;
                  tx_data     = owner_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench: per-requester packet queues feed a scoreboard; a packet-level round-robin model predicts grants and the byte stream.
module tb_uart_tx_arbiter;

   localparam int         NUM_REQ     = 4;
   localparam bit         HEADER_EN   = 1'b1;
   localparam logic [7:0] HEADER_BASE = 8'hA0;
   localparam int         TOTAL       = 3000;
   localparam int         GEN_STOP    = 2500;
   localparam int         RST_CYC     = 1500;
   localparam int         BUSY_CYC    = 800;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [8*NUM_REQ-1:0] req_data = '0;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [NUM_REQ-1:0]   req_last = '0;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_new_data;
   logic                 tx_busy = 1'b0;
   logic [NUM_REQ-1:0]   grant;
   logic                 active;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .HEADER_EN  (HEADER_EN),
      .HEADER_BASE(HEADER_BASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_data   (req_data),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .tx_data    (tx_data),
      .tx_new_data(tx_new_data),
      .tx_busy    (tx_busy),
      .grant      (grant),
      .active     (active)
   );

   int checks = 0;
   int errors = 0;

   // {last, byte} entries: drv_q is what each requester still has to present,
   // exp_q is what the UART must still receive from that requester
   logic [8:0] drv_q [NUM_REQ][$];
   logic [8:0] exp_q [NUM_REQ][$];

   logic [NUM_REQ-1:0] xfer_seen = '0;
   logic               strobe_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // reference model state
   int                 owner = -1;
   int                 last_win = NUM_REQ - 1;
   int                 cand;
   bit                 hdr_pend = 1'b0;
   bit                 arb_req = 1'b0;
   bit                 prev_strobe = 1'b0;
   bit                 end_pkt;
   logic [NUM_REQ-1:0] arb_valid = '0;
   logic [NUM_REQ-1:0] exp_ready, exp_grant;
   logic               exp_strobe;
   logic [7:0]         exp_data;
   logic [8:0]         mon_ent;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_strobe", 32'(tx_new_data), 32'd0);
            check("rst_data", 32'(tx_data), 32'd0);
            for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
            owner       = -1;
            last_win    = NUM_REQ - 1;
            hdr_pend    = 1'b0;
            arb_req     = 1'b0;
            prev_strobe = 1'b0;
            xfer_seen   = '0;
            strobe_seen = 1'b0;
         end else begin
            if (arb_req) begin
               for (int k = 1; k <= NUM_REQ; k++) begin
                  cand = (last_win + k) % NUM_REQ;
                  if (owner < 0 && arb_valid[cand]) owner = cand;
               end
               last_win = owner;
               hdr_pend = HEADER_EN;
               arb_req  = 1'b0;
            end
            exp_grant = '0;
            if (owner >= 0) exp_grant[owner] = 1'b1;
            check("active", 32'(active), 32'(owner >= 0));
            check("grant", 32'(grant), 32'(exp_grant));

            exp_ready  = '0;
            exp_strobe = 1'b0;
            exp_data   = 8'h00;
            end_pkt    = 1'b0;
            if (owner >= 0 && !tx_busy && !prev_strobe) begin
               if (hdr_pend) begin
                  exp_strobe = 1'b1;
                  exp_data   = HEADER_BASE | 8'(owner);
                  hdr_pend   = 1'b0;
               end else begin
                  exp_ready[owner] = 1'b1;
                  if (req_valid[owner] && exp_q[owner].size() > 0) begin
                     mon_ent    = exp_q[owner].pop_front();
                     exp_strobe = 1'b1;
                     exp_data   = mon_ent[7:0];
                     end_pkt    = mon_ent[8];
                  end
               end
            end
            check("tx_new_data", 32'(tx_new_data), 32'(exp_strobe));
            check("tx_data", 32'(tx_data), 32'(exp_data));
            check("req_ready", 32'(req_ready), 32'(exp_ready));

            arb_req   = (owner < 0) && (req_valid != '0);
            arb_valid = req_valid;
            if (end_pkt) owner = -1;
            prev_strobe = tx_new_data;
            xfer_seen   = req_valid & req_ready;
            strobe_seen = tx_new_data;
         end
      end
   end

   // stimulus and UART busy model
   int         stall [NUM_REQ];
   int         busy_cnt = 0;
   int         force_busy = 0;
   bit         start_pend = 1'b0;
   int         drv_len;
   logic [8:0] drv_ent;

   initial begin
      for (int i = 0; i < NUM_REQ; i++) stall[i] = 0;
      for (int cyc = 0; cyc < TOTAL; cyc++) begin
         @(posedge clk);
         #1;
         rst = (cyc < 2) || (cyc == RST_CYC);

         // UART raises busy one cycle after the cycle following a strobe
         if (busy_cnt > 0) busy_cnt--;
         if (start_pend) begin
            busy_cnt   = $urandom_range(0, 10);
            start_pend = 1'b0;
         end
         if (strobe_seen) start_pend = 1'b1;
         if (cyc == BUSY_CYC) force_busy = 50;
         else if (force_busy > 0) force_busy--;
         tx_busy = (busy_cnt > 0) || (force_busy > 0);

         for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer_seen[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            if (rst) begin
               drv_q[i].delete();
               stall[i] = 0;
            end
            if (stall[i] > 0) stall[i]--;
            else if (drv_q[i].size() > 0 && $urandom_range(0, 199) == 0) stall[i] = 20;
            if (!rst && cyc < GEN_STOP && drv_q[i].size() == 0 && $urandom_range(0, 7) == 0) begin
               drv_len = $urandom_range(1, 4);
               for (int b = 0; b < drv_len; b++) begin
                  drv_ent = {(b == drv_len - 1), 8'($urandom)};
                  drv_q[i].push_back(drv_ent);
                  exp_q[i].push_back(drv_ent);
               end
            end
            if (drv_q[i].size() > 0) begin
               drv_ent            = drv_q[i][0];
               req_valid[i]       = (stall[i] == 0) && ($urandom_range(0, 3) != 0);
               req_data[8*i +: 8] = drv_ent[7:0];
               req_last[i]        = drv_ent[8];
            end else begin
               req_valid[i]       = 1'b0;
               req_data[8*i +: 8] = 8'($urandom);
               req_last[i]        = 1'($urandom_range(0, 1));
            end
         end
      end

      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) check("drain", 32'(exp_q[i].size()), 32'd0);
      check("idle_end", 32'(active), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
